// File: rtl/alu_result_stage_if.sv
// Operand/control and result/bus signals of the ALU result stage.
// The master drives operands and enables; the slave returns ADD, flags and bus drives.
interface alu_result_stage_if;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       carry_in;
    logic       dec_en;
    logic [2:0] op;
    logic       op_start;
    logic       addsb_oe;
    logic       addadl_oe;
    logic [7:0] sb_out;
    logic       sb_drive;
    logic [7:0] adl_out;
    logic       adl_drive;
    logic [7:0] add_q;
    logic       carry_out;
    logic       ovf_out;
    logic       half_carry;
    logic       busy;
    logic       result_valid;

    modport master (
        output a_in, b_in, carry_in, dec_en, op, op_start, addsb_oe, addadl_oe,
        input  sb_out, sb_drive, adl_out, adl_drive, add_q, carry_out, ovf_out,
               half_carry, busy, result_valid
    );

    modport slave (
        input  a_in, b_in, carry_in, dec_en, op, op_start, addsb_oe, addadl_oe,
        output sb_out, sb_drive, adl_out, adl_drive, add_q, carry_out, ovf_out,
               half_carry, busy, result_valid
    );
endinterface

// File: rtl/alu_result_stage.sv
// ALU output stage: computes the selected op into the ADD hold register, latches flags,
// applies an optional one-cycle BCD correction and drives ADD onto the SB/ADL buses.
module alu_result_stage #(
    parameter int DEC_SUPPORT = 1
) (
    input logic               clk,
    input logic               reset,
    alu_result_stage_if.slave bus
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        CORRECT = 1'b1
    } state_t;

    localparam logic [2:0] OP_SUM = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_EOR = 3'b011;
    localparam logic [2:0] OP_SR  = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    // Decimal addition fix; returns {carry, value}. Carry is forced once the high digit adjusts.
    function automatic logic [8:0] bcd_add_fix(input logic [7:0] v, input logic h, input logic c);
        logic [7:0] t;
        logic       c_new;
        t     = v;
        c_new = c;
        if ((t[3:0] > 4'd9) || h) begin
            t = t + 8'h06;
        end else begin
            t = t;
        end
        if ((t[7:4] > 4'd9) || c) begin
            t     = t + 8'h60;
            c_new = 1'b1;
        end else begin
            c_new = c;
        end
        return {c_new, t};
    endfunction

    // Decimal subtraction fix: each digit that borrowed is pulled back by 6 within its nibble.
    function automatic logic [7:0] bcd_sub_fix(input logic [7:0] v, input logic h, input logic c);
        logic [7:0] t;
        t = v;
        if (!h) begin
            t[3:0] = t[3:0] - 4'h6;
        end else begin
            t[3:0] = t[3:0];
        end
        if (!c) begin
            t[7:4] = t[7:4] - 4'h6;
        end else begin
            t[7:4] = t[7:4];
        end
        return t;
    endfunction

    state_t     state_r;
    logic [7:0] add_q_r;
    logic       carry_r;
    logic       ovf_r;
    logic       half_r;
    logic       busy_r;
    logic       valid_r;
    logic       dec_sub_r;

    logic [7:0] b_eff_s;
    logic [8:0] sum9_s;
    logic [7:0] res_s;
    logic       carry_s;
    logic       ovf_s;
    logic       half_s;
    logic       op_ok_s;
    logic       arith_s;
    logic       is_sub_s;
    logic       dec_go_s;
    logic [8:0] add_fix_s;
    logic [7:0] sub_fix_s;
    logic       sb_drive_s;
    logic       adl_drive_s;
    logic [7:0] sb_out_s;
    logic [7:0] adl_out_s;

    // Combinational result and flag candidates for the op presented at the start edge.
    always_comb begin
        is_sub_s = (bus.op == OP_SUB);
        if (is_sub_s) begin
            b_eff_s = ~bus.b_in;
        end else begin
            b_eff_s = bus.b_in;
        end
        sum9_s   = {1'b0, bus.a_in} + {1'b0, b_eff_s} + {8'd0, bus.carry_in};
        res_s    = add_q_r;
        carry_s  = carry_r;
        ovf_s    = ovf_r;
        half_s   = half_r;
        op_ok_s  = 1'b1;
        arith_s  = 1'b0;
        case (bus.op)
            OP_SUM, OP_SUB: begin
                res_s   = sum9_s[7:0];
                carry_s = sum9_s[8];
                // Carry into bit 4 recovered from the full sum instead of a separate nibble adder.
                half_s  = bus.a_in[4] ^ b_eff_s[4] ^ sum9_s[4];
                ovf_s   = (bus.a_in[7] ^ sum9_s[7]) & (b_eff_s[7] ^ sum9_s[7]);
                arith_s = 1'b1;
            end
            OP_AND: res_s = bus.a_in & bus.b_in;
            OP_OR:  res_s = bus.a_in | bus.b_in;
            OP_EOR: res_s = bus.a_in ^ bus.b_in;
            OP_SR: begin
                res_s   = {bus.carry_in, bus.a_in[7:1]};
                carry_s = bus.a_in[0];
            end
            default: op_ok_s = 1'b0;
        endcase
        dec_go_s  = arith_s && bus.dec_en && (DEC_SUPPORT != 0);
        add_fix_s = bcd_add_fix(add_q_r, half_r, carry_r);
        sub_fix_s = bcd_sub_fix(add_q_r, half_r, carry_r);
    end

    // Sequencer: binary commit in IDLE, one-cycle decimal correction in CORRECT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            add_q_r   <= 8'h00;
            carry_r   <= 1'b0;
            ovf_r     <= 1'b0;
            half_r    <= 1'b0;
            busy_r    <= 1'b0;
            valid_r   <= 1'b0;
            dec_sub_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    valid_r <= 1'b0;
                    if (bus.op_start && op_ok_s) begin
                        add_q_r <= res_s;
                        carry_r <= carry_s;
                        ovf_r   <= ovf_s;
                        half_r  <= half_s;
                        if (dec_go_s) begin
                            state_r   <= CORRECT;
                            busy_r    <= 1'b1;
                            dec_sub_r <= is_sub_s;
                        end else begin
                            valid_r <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CORRECT: begin
                    if (dec_sub_r) begin
                        add_q_r <= sub_fix_s;
                    end else begin
                        add_q_r <= add_fix_s[7:0];
                        carry_r <= add_fix_s[8];
                    end
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    valid_r <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Bus drivers follow ADD directly and are blanked while a correction is pending.
    always_comb begin
        sb_drive_s  = bus.addsb_oe & ~busy_r;
        adl_drive_s = bus.addadl_oe & ~busy_r;
        if (sb_drive_s) begin
            sb_out_s = add_q_r;
        end else begin
            sb_out_s = 8'h00;
        end
        if (adl_drive_s) begin
            adl_out_s = add_q_r;
        end else begin
            adl_out_s = 8'h00;
        end
    end

    assign bus.sb_out       = sb_out_s;
    assign bus.sb_drive     = sb_drive_s;
    assign bus.adl_out      = adl_out_s;
    assign bus.adl_drive    = adl_drive_s;
    assign bus.add_q        = add_q_r;
    assign bus.carry_out    = carry_r;
    assign bus.ovf_out      = ovf_r;
    assign bus.half_carry   = half_r;
    assign bus.busy         = busy_r;
    assign bus.result_valid = valid_r;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage with hand-computed expected values.
module tb_alu_result_stage;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    alu_result_stage_if bus_if ();

    alu_result_stage #(.DEC_SUPPORT(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Presents an op for one edge, then scrambles operands to show they are not needed later.
    task automatic start_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                            input logic c, input logic d);
        bus_if.op       = o;
        bus_if.a_in     = a;
        bus_if.b_in     = b;
        bus_if.carry_in = c;
        bus_if.dec_en   = d;
        bus_if.op_start = 1'b1;
        @(posedge clk);
        #1;
        bus_if.op_start = 1'b0;
        bus_if.a_in     = 8'hFF;
        bus_if.b_in     = 8'hFF;
        bus_if.carry_in = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        reset           = 1'b1;
        bus_if.a_in     = 8'h00;
        bus_if.b_in     = 8'h00;
        bus_if.carry_in = 1'b0;
        bus_if.dec_en   = 1'b0;
        bus_if.op       = 3'b000;
        bus_if.op_start = 1'b0;
        bus_if.addsb_oe  = 1'b0;
        bus_if.addadl_oe = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk8("rst_add_q", bus_if.add_q, 8'h00);
        chk1("rst_carry", bus_if.carry_out, 1'b0);
        chk1("rst_ovf", bus_if.ovf_out, 1'b0);
        chk1("rst_half", bus_if.half_carry, 1'b0);
        chk1("rst_busy", bus_if.busy, 1'b0);
        chk1("rst_valid", bus_if.result_valid, 1'b0);

        // Binary SUM 50+50: signed overflow into A0.
        start_op(3'b000, 8'h50, 8'h50, 1'b0, 1'b0);
        chk8("sum_add_q", bus_if.add_q, 8'hA0);
        chk1("sum_carry", bus_if.carry_out, 1'b0);
        chk1("sum_ovf", bus_if.ovf_out, 1'b1);
        chk1("sum_half", bus_if.half_carry, 1'b0);
        chk1("sum_valid", bus_if.result_valid, 1'b1);
        chk1("sum_busy", bus_if.busy, 1'b0);
        step();
        chk1("sum_valid_drop", bus_if.result_valid, 1'b0);

        // Binary SUB 10-01 with no borrow in.
        start_op(3'b101, 8'h10, 8'h01, 1'b1, 1'b0);
        chk8("sub_add_q", bus_if.add_q, 8'h0F);
        chk1("sub_carry", bus_if.carry_out, 1'b1);
        chk1("sub_half", bus_if.half_carry, 1'b0);
        chk1("sub_ovf", bus_if.ovf_out, 1'b0);

        // Logic ops leave flags untouched.
        start_op(3'b001, 8'hF0, 8'h3C, 1'b0, 1'b0);
        chk8("and_add_q", bus_if.add_q, 8'h30);
        chk1("and_carry_kept", bus_if.carry_out, 1'b1);
        chk1("and_valid", bus_if.result_valid, 1'b1);
        start_op(3'b011, 8'hF0, 8'h3C, 1'b0, 1'b0);
        chk8("eor_add_q", bus_if.add_q, 8'hCC);

        // Decimal SUM 19+28: binary 41 with half carry, corrected to 47.
        start_op(3'b000, 8'h19, 8'h28, 1'b0, 1'b1);
        chk1("dsum_busy", bus_if.busy, 1'b1);
        chk1("dsum_valid_early", bus_if.result_valid, 1'b0);
        chk8("dsum_bin", bus_if.add_q, 8'h41);
        step();
        chk1("dsum_busy_done", bus_if.busy, 1'b0);
        chk1("dsum_valid", bus_if.result_valid, 1'b1);
        chk8("dsum_add_q", bus_if.add_q, 8'h47);
        chk1("dsum_carry", bus_if.carry_out, 1'b0);
        chk1("dsum_half_bin", bus_if.half_carry, 1'b1);

        // Decimal SUM 99+01 wraps to 00 with decimal carry.
        start_op(3'b000, 8'h99, 8'h01, 1'b0, 1'b1);
        step();
        chk8("dsum99_add_q", bus_if.add_q, 8'h00);
        chk1("dsum99_carry", bus_if.carry_out, 1'b1);
        chk1("dsum99_ovf", bus_if.ovf_out, 1'b0);

        // Decimal SUB 42-13: binary 2F, low digit borrowed, corrected to 29.
        start_op(3'b101, 8'h42, 8'h13, 1'b1, 1'b1);
        chk8("dsub_bin", bus_if.add_q, 8'h2F);
        step();
        chk8("dsub_add_q", bus_if.add_q, 8'h29);
        chk1("dsub_carry", bus_if.carry_out, 1'b1);
        chk1("dsub_valid", bus_if.result_valid, 1'b1);

        // Shift right pulls carry_in into bit 7.
        start_op(3'b100, 8'h81, 8'h00, 1'b1, 1'b0);
        chk8("sr_add_q", bus_if.add_q, 8'hC0);
        chk1("sr_carry", bus_if.carry_out, 1'b1);

        // op_start during CORRECT must be dropped, not queued.
        start_op(3'b000, 8'h19, 8'h28, 1'b0, 1'b1);
        start_op(3'b001, 8'hFF, 8'h0F, 1'b0, 1'b0);
        chk8("ign_add_q", bus_if.add_q, 8'h47);
        chk1("ign_valid", bus_if.result_valid, 1'b1);
        step();
        chk8("ign_add_q_after", bus_if.add_q, 8'h47);
        chk1("ign_valid_after", bus_if.result_valid, 1'b0);

        // Reserved opcode does nothing.
        start_op(3'b110, 8'h12, 8'h34, 1'b0, 1'b0);
        chk8("rsv_add_q", bus_if.add_q, 8'h47);
        chk1("rsv_valid", bus_if.result_valid, 1'b0);

        // Reset while correcting aborts everything.
        start_op(3'b000, 8'h99, 8'h01, 1'b0, 1'b1);
        chk1("rstc_busy_pre", bus_if.busy, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk8("rstc_add_q", bus_if.add_q, 8'h00);
        chk1("rstc_busy", bus_if.busy, 1'b0);
        chk1("rstc_carry", bus_if.carry_out, 1'b0);
        chk1("rstc_half", bus_if.half_carry, 1'b0);
        chk1("rstc_valid", bus_if.result_valid, 1'b0);
        step();
        chk1("rstc_valid_after", bus_if.result_valid, 1'b0);

        // Bus drive of ADD=A5 on both buses, then blanked while busy.
        start_op(3'b010, 8'hA5, 8'h00, 1'b0, 1'b0);
        chk1("bus_off_drive", bus_if.sb_drive, 1'b0);
        chk8("bus_off_sb", bus_if.sb_out, 8'h00);
        bus_if.addsb_oe  = 1'b1;
        bus_if.addadl_oe = 1'b1;
        #1;
        chk8("bus_sb", bus_if.sb_out, 8'hA5);
        chk8("bus_adl", bus_if.adl_out, 8'hA5);
        chk1("bus_sb_drive", bus_if.sb_drive, 1'b1);
        chk1("bus_adl_drive", bus_if.adl_drive, 1'b1);
        start_op(3'b000, 8'h19, 8'h28, 1'b0, 1'b1);
        chk1("busy_sb_drive", bus_if.sb_drive, 1'b0);
        chk1("busy_adl_drive", bus_if.adl_drive, 1'b0);
        chk8("busy_sb", bus_if.sb_out, 8'h00);
        chk8("busy_adl", bus_if.adl_out, 8'h00);
        step();
        chk8("post_busy_sb", bus_if.sb_out, 8'h47);
        chk1("post_busy_adl_drive", bus_if.adl_drive, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
